// File: rtl/exec_wb_stage.sv
// exec_wb_stage: ALU execute + register-file write-back stage (single-cycle ops, 8-step shift-add MUL); optional EXEC_WB_FLAGS_EN adds zero_flag/carry_flag
module exec_wb_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int SH_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              regwrite,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
`ifdef EXEC_WB_FLAGS_EN
  output logic              zero_flag,
  output logic              carry_flag,
`endif
  output logic              busy
);
`ifdef EXEC_WB_FLAGS_EN
  localparam int AW = 2 * DATA_W;
`else
  localparam int AW = DATA_W;
`endif
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
  state_t state;
  logic [AW-1:0] mcand, acc, acc_nx;
  logic [DATA_W-1:0] mplier;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] dst_r;
  logic [DATA_W:0] alu;
  logic [SH_W-1:0] sh;
  assign sh = opb[SH_W-1:0];
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  always_comb begin
    alu = op == 3'd0 ? {1'b0, opa} + {1'b0, opb} :
          op == 3'd1 ? {1'b0, opa} - {1'b0, opb} :
          op == 3'd2 ? {1'b0, opa & opb} :
          op == 3'd3 ? {1'b0, opa | opb} :
          op == 3'd4 ? {1'b0, opa ^ opb} :
          op == 3'd5 ? {1'b0, opa << sh} :
                       {1'b0, opa >> sh};
    acc_nx = acc + (mplier[0] ? mcand : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      regwrite <= 1'b0;
      wa <= '0;
      wd <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      dst_r <= '0;
`ifdef EXEC_WB_FLAGS_EN
      zero_flag <= 1'b0;
      carry_flag <= 1'b0;
`endif
    end else begin
      regwrite <= state == WB;
      if (state == IDLE && in_valid) begin
        if (op == 3'd7) begin
          mcand <= AW'(opa);
          mplier <= opb;
          acc <= '0;
          cnt <= CW'(DATA_W);
          dst_r <= dst;
          state <= MUL;
        end else begin
          wd <= alu[DATA_W-1:0];
          wa <= dst;
          state <= WB;
`ifdef EXEC_WB_FLAGS_EN
          zero_flag <= alu[DATA_W-1:0] == '0;
          carry_flag <= alu[DATA_W];
`endif
        end
      end else if (state == MUL) begin
        acc <= acc_nx;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          wd <= acc_nx[DATA_W-1:0];
          wa <= dst_r;
          state <= WB;
`ifdef EXEC_WB_FLAGS_EN
          zero_flag <= acc_nx[DATA_W-1:0] == '0;
          carry_flag <= |acc_nx[AW-1:DATA_W];
`endif
        end
      end else if (state == WB) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_exec_wb_stage.sv
// tb_exec_wb_stage: table, random and sequence checks of exec_wb_stage against an arithmetic model
module tb_exec_wb_stage;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic in_ready, regwrite, busy;
  logic [2:0] op = '0, dst = '0, wa;
  logic [7:0] opa = '0, opb = '0, wd;
`ifdef EXEC_WB_FLAGS_EN
  logic zero_flag, carry_flag;
`endif
  int tests = 0, fails = 0, consec = 0;
  logic prev_rw = 1'b0;
  logic [10:0] wq[$];
  typedef struct {
    logic [2:0] o;
    logic [2:0] d;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] wd;
    int lat;
  } vec_t;
  vec_t tbl[12];
  always #5 clk = ~clk;
  exec_wb_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .dst(dst),
    .opa(opa),
    .opb(opb),
    .regwrite(regwrite),
    .wa(wa),
    .wd(wd),
`ifdef EXEC_WB_FLAGS_EN
    .zero_flag(zero_flag),
    .carry_flag(carry_flag),
`endif
    .busy(busy)
  );
  always @(negedge clk) begin
    if (regwrite && prev_rw) consec <= consec + 1;
    prev_rw <= regwrite;
    if (regwrite) wq.push_back({wa, wd});
  end
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  function automatic int mraw(input int o, input int a, input int b);
    case (o)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << (b % 8);
      6: return a >> (b % 8);
      default: return a * b;
    endcase
  endfunction
  function automatic int mwd(input int o, input int a, input int b);
    return mraw(o, a, b) & 255;
  endfunction
  function automatic int mcarry(input int o, input int a, input int b);
    return (o == 0 || o == 7) ? int'(mraw(o, a, b) > 255) : o == 1 ? int'(a < b) : 0;
  endfunction
  task automatic wait_ready(input string n);
    int w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({n, " ready"}, int'(in_ready), 1);
  endtask
  task automatic do_op(input logic [2:0] o, input logic [2:0] d, input logic [7:0] a, input logic [7:0] b,
                       input int ewd, input int elat, input string n);
    int lat, bz;
    wait_ready(n);
    op = o; dst = d; opa = a; opb = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op = 3'($urandom); dst = 3'($urandom); opa = 8'($urandom); opb = 8'($urandom);
    lat = 1; bz = 0;
    while (!regwrite && lat < 40) begin
      bz += int'(busy);
      @(negedge clk);
      lat++;
    end
    chk({n, " latency"}, lat, elat);
    chk({n, " wa"}, int'(wa), int'(d));
    chk({n, " wd"}, int'(wd), ewd);
    chk({n, " busy cycles"}, bz, elat - 1);
`ifdef EXEC_WB_FLAGS_EN
    chk({n, " zero"}, int'(zero_flag), int'(ewd == 0));
    chk({n, " carry"}, int'(carry_flag), mcarry(int'(o), int'(a), int'(b)));
`endif
    @(negedge clk);
    chk({n, " single pulse"}, int'(regwrite), 0);
  endtask
  initial begin
    tbl[0]  = '{3'd0, 3'd1, 8'd200, 8'd100, 8'd44, 2};
    tbl[1]  = '{3'd1, 3'd2, 8'd5, 8'd7, 8'd254, 2};
    tbl[2]  = '{3'd7, 3'd3, 8'd13, 8'd11, 8'd143, 10};
    tbl[3]  = '{3'd7, 3'd4, 8'd16, 8'd16, 8'd0, 10};
    tbl[4]  = '{3'd5, 3'd5, 8'h81, 8'd1, 8'h02, 2};
    tbl[5]  = '{3'd6, 3'd6, 8'h81, 8'd9, 8'h40, 2};
    tbl[6]  = '{3'd2, 3'd7, 8'hF0, 8'h3C, 8'h30, 2};
    tbl[7]  = '{3'd3, 3'd0, 8'hF0, 8'h0F, 8'hFF, 2};
    tbl[8]  = '{3'd4, 3'd1, 8'hAA, 8'hFF, 8'h55, 2};
    tbl[9]  = '{3'd5, 3'd2, 8'h5A, 8'd0, 8'h5A, 2};
    tbl[10] = '{3'd7, 3'd3, 8'd255, 8'd255, 8'd1, 10};
    tbl[11] = '{3'd0, 3'd4, 8'd0, 8'd0, 8'd0, 2};
    repeat (2) @(negedge clk);
    chk("reset regwrite", int'(regwrite), 0);
    chk("reset wa", int'(wa), 0);
    chk("reset wd", int'(wd), 0);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset regwrite", int'(regwrite), 0);
    for (int i = 0; i < 12; i++)
      do_op(tbl[i].o, tbl[i].d, tbl[i].a, tbl[i].b, int'(tbl[i].wd), tbl[i].lat, $sformatf("vec%0d", i));
    for (int i = 0; i < 120; i++) begin
      logic [2:0] o, d;
      logic [7:0] a, b;
      o = 3'($urandom); d = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      do_op(o, d, a, b, mwd(int'(o), int'(a), int'(b)), o == 3'd7 ? 10 : 2, $sformatf("rand%0d op%0d", i, o));
    end
    begin
      int k = 0;
      logic took = 1'b0;
      wait_ready("hs");
      wq.delete();
      op = 3'd7; dst = 3'd3; opa = 8'd7; opb = 8'd6; in_valid = 1'b1;
      @(negedge clk);
      while (!took && k < 40) begin
        if (in_ready) begin
          op = 3'd0; dst = 3'd5; opa = 8'd20; opb = 8'd30; took = 1'b1;
        end else begin
          op = 3'($urandom); dst = 3'($urandom); opa = 8'($urandom); opb = 8'($urandom);
        end
        @(negedge clk);
        k++;
      end
      in_valid = 1'b0;
      chk("hs first idle", k, 10);
      chk("hs second accepted", int'(busy), 1);
      repeat (4) @(negedge clk);
      chk("hs write count", wq.size(), 2);
      chk("hs write0", wq.size() > 0 ? int'(wq[0]) : -1, int'({3'd3, 8'd42}));
      chk("hs write1", wq.size() > 1 ? int'(wq[1]) : -1, int'({3'd5, 8'd50}));
    end
    do_op(3'd0, 3'd5, 8'd3, 8'd4, 7, 2, "pre-abort");
    wait_ready("abort");
    op = 3'd7; dst = 3'd6; opa = 8'd9; opb = 8'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort regwrite", int'(regwrite), 0);
    chk("abort wa", int'(wa), 0);
    chk("abort wd", int'(wd), 0);
    chk("abort in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    repeat (15) @(negedge clk);
    chk("abort no write", wq.size(), 0);
    chk("abort idle", int'(in_ready), 1);
    chk("no consecutive regwrite", consec, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
- Execute/write-back stage directly downstream of the 8x8 register file.
- Consumes the two read operands (rd1/rd2) plus a decoded opcode and destination, computes an ALU result, and drives the register file write port (regwrite/wa/wd).
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SHL, SHR. MUL is an iterative shift-add multiply taking DATA_W cycles.
- Upstream issue uses a valid/ready handshake.

Parameters:
- DATA_W, 8, operand/result width; matches register file data width.
- ADDR_W, 3, register address width; matches register file address width.
- SH_W, 3, shift-amount bits taken from opb; equals log2(DATA_W).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage can accept; equals (state==IDLE).
- op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- dst  input  ADDR_W  destination register.
- opa  input  DATA_W  operand A (from rd1).
- opb  input  DATA_W  operand B (from rd2).
- regwrite  output  1  register file write enable, one-cycle pulse.
- wa  output  ADDR_W  register file write address.
- wd  output  DATA_W  register file write data.
- busy  output  1  high in MUL or WB.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; regwrite=0, wa=0, wd=0; internal multiplier registers cleared. in_ready=1 once state is IDLE.
- States: IDLE, MUL, WB.
- Accept: on a rising edge with in_valid && in_ready, latch op, dst, opa and opb.
  - Non-MUL: the result is computed and registered into wd, dst into wa, and state goes to WB.
  - MUL: load the multiplicand, the multiplier, accumulator=0 and count=DATA_W; state goes to MUL.
- MUL state, each cycle:
  - If the multiplier LSB is 1, accumulator += multiplicand (DATA_W-bit, wrapping).
  - Multiplicand <<= 1; multiplier >>= 1; count -= 1.
  - When count reaches 0: wd = accumulator, wa = dst, state goes to WB.
  - Fixed latency regardless of operand values (no early exit).
- WB state: regwrite=1 for exactly one cycle, then state returns to IDLE. wa and wd hold their values after WB until the next WB loads.
- Timing:
  - Accept at edge N (non-MUL): regwrite is high in the cycle between edges N+1 and N+2; the register file captures the result at edge N+2.
  - MUL: regwrite is high DATA_W cycles later than for non-MUL ops.
  - Throughput: one non-MUL op per 2 cycles.
- Arithmetic rules:
  - ADD and SUB are modulo 2^DATA_W.
  - SHL and SHR are logical shifts by opb[SH_W-1:0], zero fill. A shift of 0 passes opa unchanged.
  - MUL returns the low DATA_W bits of the product.
- in_valid while not ready: ignored. No input is sampled and nothing is queued; upstream must hold its inputs.
- dst=0: written like any other register; no special case.
- Input changes after accept (opa/opb/op/dst): no effect, because the inputs were latched.
- Reset mid-MUL or in WB: the operation is aborted, no regwrite is produced, and the stage is in IDLE after reset release.
- regwrite is never asserted in two consecutive cycles.

Optional Feature:
- Macro: EXEC_WB_FLAGS_EN.
- When defined, add outputs zero_flag (1) and carry_flag (1). Both are registered when wd is loaded, reset to 0, and hold until the next load.
  - zero_flag = (result==0).
  - carry_flag:
    - ADD: carry-out.
    - SUB: borrow (opa<opb).
    - MUL: 1 if any bit above DATA_W-1 of the full product is nonzero.
    - All other ops: 0.
  - For MUL, the full product is tracked with a 2*DATA_W accumulator.
- When not defined: the ports and the extra accumulator bits are absent; everything else is identical.

Test Plan:
- ADD wraps: reset, then accept op=000, dst=1, opa=200, opb=100. Required: regwrite pulses once, two edges after accept, with wa=1 and wd=44. With flags: carry=1, zero=0.
- SUB borrow: op=001, dst=2, opa=5, opb=7. Required: wd=254, wa=2. With flags: carry=1.
- MUL latency: op=111, dst=3, opa=13, opb=11. Required: busy high, in_ready low for 9 cycles (8 MUL cycles + 1 WB), regwrite once with wd=143. Separately, opa=16, opb=16 gives wd=0 (with flags: zero=1, carry=1).
- Shifts: SHL opa=8'h81, opb=1 gives wd=8'h02. SHR opa=8'h81, opb=9 (uses 3 LSBs, so shift 1) gives wd=8'h40.
- Handshake: hold in_valid=1 with changing opa during WB and MUL. Required: no extra accept; the second op is accepted only in the first IDLE cycle, and regwrite is never high on two consecutive cycles.
- Reset mid-MUL: assert rst_n=0 at MUL cycle 4. Required: regwrite=0, wa=0, wd=0 immediately; no write after release; in_ready=1.
